// File: rtl/input_queue_vc.sv
// Router input port: per-VC flit/mask FIFOs, round-robin pop, multicast hold-and-serve.
// Define IQ_STATS_EN to add per-VC served-flit counters (stats_vc / stats_cnt).
module input_queue_vc #(
  parameter int FW = 64,
  parameter int P  = 7,
  parameter int V  = 4,
  parameter int VW = 2,
  parameter int B  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flit_in_wr,
  input  logic [VW-1:0] flit_in_vc,
  input  logic [FW-1:0] flit_in,
  input  logic [P-1:0]  dest_in,
  output logic          flit_rel,
  output logic [VW-1:0] flit_rel_vc,
  output logic [P-1:0]  dest_port_req,
  input  logic [P-1:0]  grant_dest_port,
  output logic [FW-1:0] flit_to_crossbar,
  output logic [VW-1:0] flit_to_crossbar_vc,
  output logic [V-1:0]  vc_not_empty,
  output logic          overflow_err
`ifdef IQ_STATS_EN
  ,
  input  logic [VW-1:0] stats_vc,
  output logic [15:0]   stats_cnt
`endif
);
  localparam int D = 1 << B;
  localparam logic [B:0] FULL = (B+1)'(D);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] rr_q, rr_d;
  logic          rel_q, rel_d;
  logic [VW-1:0] rel_vc_q, rel_vc_d;
  logic [P-1:0]  rem_q, rem_d;
  logic [FW-1:0] xb_flit_q, xb_flit_d;
  logic [VW-1:0] xb_vc_q, xb_vc_d;
  logic [V-1:0]  ne_q, ne_d;
  logic          ovf_q, ovf_d;

  logic [VW-1:0] sel_vc_q;
  logic [FW-1:0] stage_flit_q;
  logic [P-1:0]  stage_mask_q;

  logic [B-1:0]  wr_ptr_q [V];
  logic [B-1:0]  rd_ptr_q [V];
  logic [B:0]    cnt_q    [V];
  logic [B:0]    cnt_d    [V];
  logic [FW-1:0] flit_mem [V][D];
  logic [P-1:0]  mask_mem [V][D];

  logic          vc_ok;
  logic          push;
  logic          pop;
  logic          served;
  logic [V-1:0]  push_v;
  logic [V-1:0]  pop_v;

  function automatic logic [VW-1:0] inc_vc(input logic [VW-1:0] v);
    if (int'(v) >= V - 1) return '0;
    return v + 1'b1;
  endfunction

  function automatic logic [VW-1:0] rr_pick(input logic [V-1:0] ne, input logic [VW-1:0] start);
    logic [VW-1:0] pick;
    logic [VW-1:0] k;
    int            idx;
    pick = '0;
    for (int i = V - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % V;
      k   = VW'(idx);
      if (ne[k]) pick = k;
    end
    return pick;
  endfunction

  // A pop only ever happens in IDLE, and the registered release pulse marks it,
  // so a write to a full FIFO can be accepted when that same FIFO is popping.
  always_comb begin
    vc_ok  = ({1'b0, flit_in_vc} < (VW+1)'(V));
    pop    = rel_q;
    push   = 1'b0;
    push_v = '0;
    pop_v  = '0;
    ne_d   = '0;
    ovf_d  = ovf_q;
    for (int v = 0; v < V; v++) begin
      pop_v[v] = pop && (rel_vc_q == VW'(v));
    end
    if (flit_in_wr) begin
      if (!vc_ok) begin
        ovf_d = 1'b1;
      end else if ((cnt_q[flit_in_vc] == FULL) && !pop_v[flit_in_vc]) begin
        ovf_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
    for (int v = 0; v < V; v++) begin
      push_v[v] = push && (flit_in_vc == VW'(v));
      cnt_d[v]  = cnt_q[v] + (B+1)'(push_v[v]) - (B+1)'(pop_v[v]);
      ne_d[v]   = (cnt_d[v] != '0);
    end
  end

  // Release pulse is computed one cycle ahead so it comes straight from a register.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    rem_d     = rem_q;
    xb_flit_d = xb_flit_q;
    xb_vc_d   = xb_vc_q;
    served    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rel_q) state_d = LOAD;
      end
      LOAD: begin
        if (stage_mask_q == '0) begin
          state_d = IDLE;
          rr_d    = inc_vc(sel_vc_q);
        end else begin
          state_d   = SERVE;
          rem_d     = stage_mask_q;
          xb_flit_d = stage_flit_q;
          xb_vc_d   = sel_vc_q;
        end
      end
      SERVE: begin
        rem_d = rem_q & ~grant_dest_port;
        if (rem_d == '0) begin
          state_d = IDLE;
          rr_d    = inc_vc(xb_vc_q);
          served  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
    rel_d    = (state_d == IDLE) && (|ne_d);
    rel_vc_d = rel_d ? rr_pick(ne_d, rr_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      rel_q     <= 1'b0;
      rel_vc_q  <= '0;
      rem_q     <= '0;
      xb_flit_q <= '0;
      xb_vc_q   <= '0;
      ne_q      <= '0;
      ovf_q     <= 1'b0;
      for (int v = 0; v < V; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      rel_q     <= rel_d;
      rel_vc_q  <= rel_vc_d;
      rem_q     <= rem_d;
      xb_flit_q <= xb_flit_d;
      xb_vc_q   <= xb_vc_d;
      ne_q      <= ne_d;
      ovf_q     <= ovf_d;
      for (int v = 0; v < V; v++) begin
        if (push_v[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
        if (pop_v[v])  rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
        cnt_q[v] <= cnt_d[v];
      end
    end
  end

  // The head is copied out on the pop edge: a same-edge push into a full FIFO
  // reuses that slot, so it cannot be read from the array a cycle later.
  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem[flit_in_vc][wr_ptr_q[flit_in_vc]] <= flit_in;
      mask_mem[flit_in_vc][wr_ptr_q[flit_in_vc]] <= dest_in;
    end
    if (pop) begin
      stage_flit_q <= flit_mem[rel_vc_q][rd_ptr_q[rel_vc_q]];
      stage_mask_q <= mask_mem[rel_vc_q][rd_ptr_q[rel_vc_q]];
      sel_vc_q     <= rel_vc_q;
    end
  end

`ifdef IQ_STATS_EN
  logic [15:0] stat_q [V];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < V; v++) stat_q[v] <= '0;
    end else if (served && (stat_q[xb_vc_q] != 16'hFFFF)) begin
      stat_q[xb_vc_q] <= stat_q[xb_vc_q] + 16'd1;
    end
  end

  assign stats_cnt = ({1'b0, stats_vc} < (VW+1)'(V)) ? stat_q[stats_vc] : 16'd0;
`endif

  assign flit_rel            = rel_q;
  assign flit_rel_vc         = rel_vc_q;
  assign dest_port_req       = rem_q;
  assign flit_to_crossbar    = xb_flit_q;
  assign flit_to_crossbar_vc = xb_vc_q;
  assign vc_not_empty        = ne_q;
  assign overflow_err        = ovf_q;

endmodule

// File: tb/tb_input_queue_vc.sv
// Testbench for input_queue_vc: directed vector table, corner sequences, randomized model check.
module tb_input_queue_vc;
  localparam int FW = 64, P = 7, V = 4, VW = 2, B = 2, D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flit_in_wr;
  logic [VW-1:0] flit_in_vc;
  logic [FW-1:0] flit_in;
  logic [P-1:0]  dest_in;
  logic          flit_rel;
  logic [VW-1:0] flit_rel_vc;
  logic [P-1:0]  dest_port_req;
  logic [P-1:0]  grant_dest_port;
  logic [FW-1:0] flit_to_crossbar;
  logic [VW-1:0] flit_to_crossbar_vc;
  logic [V-1:0]  vc_not_empty;
  logic          overflow_err;
`ifdef IQ_STATS_EN
  logic [VW-1:0] stats_vc;
  logic [15:0]   stats_cnt;
`endif

  input_queue_vc #(.FW(FW), .P(P), .V(V), .VW(VW), .B(B)) dut (
    .clk(clk), .rst(rst),
    .flit_in_wr(flit_in_wr), .flit_in_vc(flit_in_vc), .flit_in(flit_in), .dest_in(dest_in),
    .flit_rel(flit_rel), .flit_rel_vc(flit_rel_vc), .dest_port_req(dest_port_req),
    .grant_dest_port(grant_dest_port), .flit_to_crossbar(flit_to_crossbar),
    .flit_to_crossbar_vc(flit_to_crossbar_vc), .vc_not_empty(vc_not_empty),
    .overflow_err(overflow_err)
`ifdef IQ_STATS_EN
    , .stats_vc(stats_vc), .stats_cnt(stats_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int served_q[$];

  typedef struct {
    logic          wr;
    logic [VW-1:0] vc;
    logic [FW-1:0] flit;
    logic [P-1:0]  dest;
    logic [P-1:0]  grant;
    logic          rel;
    logic [VW-1:0] rel_vc;
    logic [P-1:0]  req;
    logic [V-1:0]  ne;
    logic          chk_xb;
    logic [FW-1:0] xb_flit;
    logic [VW-1:0] xb_vc;
  } vec_t;
  vec_t tbl [10];

  typedef struct { logic [FW-1:0] flit; logic [P-1:0] mask; } ent_t;
  ent_t          mq [V][$];
  int            m_phase, m_rr, m_sel, m_vc;
  ent_t          m_stage;
  logic [FW-1:0] m_flit;
  logic [P-1:0]  m_rem;
  logic          m_ovf;
  int            m_served [V];

  int            pk;
  logic          exp_rel;
  logic [V-1:0]  exp_ne;
  logic          r_wr;
  logic [VW-1:0] r_vc;
  logic [FW-1:0] r_flit;
  logic [P-1:0]  r_dest, r_grant;
  ent_t          r_ent;
  int            wcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [VW-1:0] vc, input logic [FW-1:0] f,
                       input logic [P-1:0] d, input logic [P-1:0] g);
    flit_in_wr      = wr;
    flit_in_vc      = vc;
    flit_in         = f;
    dest_in         = d;
    grant_dest_port = g;
  endtask

  task automatic step_rec();
    if (flit_rel) served_q.push_back(int'(flit_rel_vc));
    tick();
  endtask

  task automatic collect(input int want, input int budget, input string name);
    int c;
    c = 0;
    while (served_q.size() < want && c < budget) begin
      step_rec();
      c++;
    end
    chk({name, "_rel_count"}, 64'(served_q.size()), 64'(want));
  endtask

  function automatic logic [63:0] enc_served();
    logic [63:0] e;
    e = '0;
    foreach (served_q[i]) e = (e << 4) | 64'(served_q[i]);
    return e;
  endfunction

  function automatic vec_t mk(input logic wr, input int vc, input logic [FW-1:0] f,
                              input logic [P-1:0] d, input logic [P-1:0] g,
                              input logic rel, input int rvc, input logic [P-1:0] req,
                              input logic [V-1:0] ne, input logic cx,
                              input logic [FW-1:0] xf, input int xv);
    vec_t r;
    r.wr = wr; r.vc = VW'(vc); r.flit = f; r.dest = d; r.grant = g;
    r.rel = rel; r.rel_vc = VW'(rvc); r.req = req; r.ne = ne;
    r.chk_xb = cx; r.xb_flit = xf; r.xb_vc = VW'(xv);
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      mq[v].delete();
      m_served[v] = 0;
    end
    m_phase = 0; m_rr = 0; m_sel = 0; m_vc = 0;
    m_rem = '0; m_ovf = 1'b0; m_flit = '0;
  endtask

  function automatic int m_pick();
    for (int i = 0; i < V; i++) begin
      if (mq[(m_rr + i) % V].size() != 0) return (m_rr + i) % V;
    end
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef IQ_STATS_EN
    stats_vc = '0;
`endif
    rst = 1'b1;
    drive(0, 0, '0, '0, '0);
    tick();
    tick();
    chk("rst_rel", flit_rel, 0);
    chk("rst_rel_vc", flit_rel_vc, 0);
    chk("rst_req", dest_port_req, 0);
    chk("rst_xb_flit", flit_to_crossbar, 0);
    chk("rst_xb_vc", flit_to_crossbar_vc, 0);
    chk("rst_ne", vc_not_empty, 0);
    chk("rst_ovf", overflow_err, 0);
    rst = 1'b0;

    // unicast on VC1, then multicast on VC3 with partial grants
    tbl[0] = mk(1, 1, 64'hA1A1, 7'b0000100, 7'b0,       1, 1, 7'b0,       4'b0010, 0, '0, 0);
    tbl[1] = mk(0, 0, '0,       7'b0,       7'b0,       0, 0, 7'b0,       4'b0000, 0, '0, 0);
    tbl[2] = mk(0, 0, '0,       7'b0,       7'b0,       0, 0, 7'b0000100, 4'b0000, 1, 64'hA1A1, 1);
    tbl[3] = mk(0, 0, '0,       7'b0,       7'b0000100, 0, 0, 7'b0,       4'b0000, 0, '0, 0);
    tbl[4] = mk(1, 3, 64'hB3B3, 7'b0010011, 7'b0,       1, 3, 7'b0,       4'b1000, 0, '0, 0);
    tbl[5] = mk(0, 0, '0,       7'b0,       7'b0,       0, 0, 7'b0,       4'b0000, 0, '0, 0);
    tbl[6] = mk(0, 0, '0,       7'b0,       7'b0,       0, 0, 7'b0010011, 4'b0000, 1, 64'hB3B3, 3);
    tbl[7] = mk(0, 0, '0,       7'b0,       7'b1100001, 0, 0, 7'b0010010, 4'b0000, 1, 64'hB3B3, 3);
    tbl[8] = mk(0, 0, '0,       7'b0,       7'b0010010, 0, 0, 7'b0,       4'b0000, 0, '0, 0);
    tbl[9] = mk(0, 0, '0,       7'b0,       7'b0,       0, 0, 7'b0,       4'b0000, 0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wr, tbl[i].vc, tbl[i].flit, tbl[i].dest, tbl[i].grant);
      tick();
      chk($sformatf("vec%0d_rel", i), flit_rel, tbl[i].rel);
      if (tbl[i].rel) chk($sformatf("vec%0d_rel_vc", i), flit_rel_vc, tbl[i].rel_vc);
      chk($sformatf("vec%0d_req", i), dest_port_req, tbl[i].req);
      chk($sformatf("vec%0d_ne", i), vc_not_empty, tbl[i].ne);
      if (tbl[i].chk_xb) begin
        chk($sformatf("vec%0d_xb_flit", i), flit_to_crossbar, tbl[i].xb_flit);
        chk($sformatf("vec%0d_xb_vc", i), flit_to_crossbar_vc, tbl[i].xb_vc);
      end
    end

    // round-robin: one flit per VC, immediate grants, then VC0 and VC2 only
    served_q.delete();
    for (int v = 0; v < V; v++) begin
      drive(1, VW'(v), 64'hC0 + 64'(v), 7'b0001000, 7'h7F);
      step_rec();
    end
    drive(0, 0, '0, '0, 7'h7F);
    collect(4, 40, "rr_all");
    chk("rr_all_order", enc_served(), 64'h0123);
    served_q.delete();
    drive(1, 0, 64'hD0, 7'b0000001, 7'h7F);
    step_rec();
    drive(1, 2, 64'hD2, 7'b0000001, 7'h7F);
    step_rec();
    drive(0, 0, '0, '0, 7'h7F);
    collect(2, 40, "rr_sub");
    chk("rr_sub_order", enc_served(), 64'h02);
    repeat (6) tick();
    chk("rr_drained_ne", vc_not_empty, 0);

    // overflow: hold a VC0 flit ungranted, push five into VC2
    drive(1, 0, 64'hE0, 7'b0000001, 7'b0);
    step_rec();
    drive(0, 0, '0, '0, 7'b0);
    step_rec();
    step_rec();
    chk("ovf_hold_req", dest_port_req, 7'b0000001);
    served_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2, 64'hE20 + 64'(i), 7'b0000010, 7'b0);
      step_rec();
      chk($sformatf("ovf_after_write%0d", i + 1), overflow_err, (i == 4));
    end
    chk("ovf_ne_vc2", vc_not_empty, 4'b0100);
    drive(1, 1, 64'hE10, 7'b0000100, 7'b0);
    step_rec();
    chk("ovf_ne_vc1", vc_not_empty, 4'b0110);
    chk("ovf_sticky1", overflow_err, 1);
    drive(0, 0, '0, '0, 7'h7F);
    collect(5, 60, "ovf_drain");
    chk("ovf_drain_order", enc_served(), 64'h12222);
    chk("ovf_sticky2", overflow_err, 1);
    repeat (4) tick();
    chk("ovf_drained_ne", vc_not_empty, 0);
    rst = 1'b1;
    tick();
    chk("ovf_cleared_by_rst", overflow_err, 0);
    rst = 1'b0;

    // zero-mask flit on VC1 is released but never requests
    served_q.delete();
    drive(1, 1, 64'h2E50, 7'b0, 7'b0);
    step_rec();
    drive(1, 2, 64'h2E52, 7'b0000001, 7'b0);
    step_rec();
    drive(0, 0, '0, '0, 7'b0);
    wcnt = 0;
    while (dest_port_req == '0 && wcnt < 20) begin
      step_rec();
      wcnt++;
    end
    chk("zm_rel_order", enc_served(), 64'h12);
    chk("zm_req", dest_port_req, 7'b0000001);
    chk("zm_xb_vc", flit_to_crossbar_vc, 2);
    chk("zm_xb_flit", flit_to_crossbar, 64'h2E52);
    drive(0, 0, '0, '0, 7'h7F);
    repeat (3) tick();

    // reset while serving a multicast flit with another VC still queued
    drive(1, 3, 64'hF3, 7'b0000110, 7'b0);
    tick();
    drive(1, 1, 64'hF1, 7'b0000001, 7'b0);
    tick();
    drive(0, 0, '0, '0, 7'b0);
    wcnt = 0;
    while (dest_port_req !== 7'b0000110 && wcnt < 10) begin
      tick();
      wcnt++;
    end
    chk("rstmid_pre_req", dest_port_req, 7'b0000110);
    chk("rstmid_pre_ne", vc_not_empty, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_rel", flit_rel, 0);
    chk("rstmid_rel_vc", flit_rel_vc, 0);
    chk("rstmid_req", dest_port_req, 0);
    chk("rstmid_xb_flit", flit_to_crossbar, 0);
    chk("rstmid_xb_vc", flit_to_crossbar_vc, 0);
    chk("rstmid_ne", vc_not_empty, 0);
    tick();
    rst = 1'b0;
    served_q.delete();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rstmid_after%0d_req", i), dest_port_req, 0);
      step_rec();
    end
    chk("rstmid_no_credit", 64'(served_q.size()), 0);
`ifdef IQ_STATS_EN
    stats_vc = 2'd3;
    #1;
    chk("rstmid_stats_vc3", stats_cnt, 0);
`endif

    // randomized traffic against the queue model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pk      = m_pick();
      exp_rel = (m_phase == 0) && (pk >= 0);
      exp_ne  = '0;
      for (int v = 0; v < V; v++) exp_ne[v] = (mq[v].size() != 0);
      chk("rnd_rel", flit_rel, exp_rel);
      if (exp_rel) chk("rnd_rel_vc", flit_rel_vc, 64'(pk));
      chk("rnd_req", dest_port_req, (m_phase == 2) ? m_rem : 7'b0);
      chk("rnd_ne", vc_not_empty, exp_ne);
      chk("rnd_ovf", overflow_err, m_ovf);
      if (m_phase == 2) begin
        chk("rnd_xb_flit", flit_to_crossbar, m_flit);
        chk("rnd_xb_vc", flit_to_crossbar_vc, 64'(m_vc));
      end

      r_wr    = ($urandom_range(0, 99) < 45);
      r_vc    = VW'($urandom_range(0, V - 1));
      r_flit  = {$urandom, $urandom};
      r_dest  = P'($urandom_range(1, (1 << P) - 1));
      r_grant = ($urandom_range(0, 3) == 0) ? '0 : P'($urandom_range(0, (1 << P) - 1));
      drive(r_wr, r_vc, r_flit, r_dest, r_grant);

      if (m_phase == 0) begin
        if (pk >= 0) begin
          m_stage = mq[pk].pop_front();
          m_sel   = pk;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_stage.mask == '0) begin
          m_phase = 0;
          m_rr    = (m_sel + 1) % V;
        end else begin
          m_phase = 2;
          m_flit  = m_stage.flit;
          m_rem   = m_stage.mask;
          m_vc    = m_sel;
        end
      end else begin
        m_rem = m_rem & ~r_grant;
        if (m_rem == '0) begin
          m_phase = 0;
          m_rr    = (m_vc + 1) % V;
          m_served[m_vc]++;
        end
      end
      if (r_wr) begin
        if (mq[r_vc].size() < D) begin
          r_ent.flit = r_flit;
          r_ent.mask = r_dest;
          mq[r_vc].push_back(r_ent);
        end else begin
          m_ovf = 1'b1;
        end
      end
      tick();
    end
`ifdef IQ_STATS_EN
    for (int v = 0; v < V; v++) begin
      stats_vc = VW'(v);
      #1;
      chk($sformatf("rnd_stats_vc%0d", v), stats_cnt, 64'(m_served[v]));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_queue_vc.md
Name: input_queue_vc

Overview:
Next-generation router input port: V virtual channels share one physical input, each with its own flit FIFO and destination-mask FIFO. A round-robin selector picks one non-empty VC and pops its head flit. The flit is held while its multicast destination mask is served across possibly several grant cycles. Credits are returned per VC; the block sits between the link receiver/route computation and the switch allocator/crossbar.

Parameters:
FW, 64, flit width in bits
P, 7, number of router output ports (width of destination mask)
V, 4, number of virtual channels (>=2)
VW, 2, VC index width; must satisfy 2**VW >= V
B, 2, log2 of FIFO depth per VC (depth D = 2**B)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flit_in_wr  input  1  write strobe for incoming flit
flit_in_vc  input  VW  target VC of incoming flit
flit_in  input  FW  incoming flit
dest_in  input  P  precomputed multicast destination mask for flit_in
flit_rel  output  1  one-cycle credit return pulse
flit_rel_vc  output  VW  VC whose credit is returned (valid when flit_rel=1)
dest_port_req  output  P  outstanding output-port requests of the held flit
grant_dest_port  input  P  output ports granted this cycle
flit_to_crossbar  output  FW  held flit
flit_to_crossbar_vc  output  VW  VC of held flit
vc_not_empty  output  V  per-VC FIFO occupancy flag
overflow_err  output  1  sticky: write to a full VC FIFO

Behaviour:
- Reset: FSM=IDLE, all FIFOs empty, rr pointer=0, flit_rel=0, flit_rel_vc=0, dest_port_req=0, flit_to_crossbar=0, flit_to_crossbar_vc=0, vc_not_empty=0, overflow_err=0. Reset mid-service discards the held flit, all FIFO contents and all outstanding requests; no credit is returned for them.
- Write: on flit_in_wr, the flit and dest_in are pushed into the FIFO of flit_in_vc. A write to a full FIFO is dropped and sets overflow_err, which stays set until reset. A flit_in_vc >= V is also dropped and sets overflow_err. Pointers wrap modulo D. Simultaneous push and pop on the same VC is legal, including when the FIFO is full (the pop frees the slot first).
- FSM states:
  - IDLE: if any vc_not_empty bit is set, select the first non-empty VC searching from the rr pointer upward (mod V). Pop that VC, pulse flit_rel=1 with flit_rel_vc=that VC, then go to LOAD. Otherwise stay in IDLE.
  - LOAD: the FIFO head (flit, mask) is registered into the hold registers; go to SERVE. A zero mask instead goes to IDLE: the flit is discarded with no request.
  - SERVE: dest_port_req = remaining mask. flit_to_crossbar and flit_to_crossbar_vc are stable from the registers. On grant, remaining <= remaining & ~grant_dest_port; grant bits outside remaining are ignored. When the next remaining value is 0, return to IDLE and set rr pointer = served VC + 1 (mod V).
- Timing: a flit written at edge t gives rel at cycle t+1 (IDLE). Requests are first visible at t+3 (SERVE). After the last grant, the next pop occurs no earlier than the following cycle. Minimum per-flit service period is 3 cycles.
- flit_rel is asserted only in IDLE on a pop, never twice for one flit.
- dest_port_req is 0 outside SERVE.

Optional Feature:
IQ_STATS_EN: when defined, adds input stats_vc [VW-1:0] and output stats_cnt [15:0]. stats_cnt shows a per-VC 16-bit counter of fully served flits (SERVE->IDLE transitions with nonzero mask). Counters saturate at 16'hFFFF and reset to 0. When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single unicast: write VC1, dest 7'b0000100; flit_rel at t+1 with vc=1; req=0000100 at t+3; grant at t+3 -> req=0 at t+4, FSM IDLE.
- Multicast partial grants: dest 7'b0010011; grant 0000001, then 0010010 -> req becomes 0010010, then 0; exactly one flit_rel issued.
- Round-robin: fill VC0..VC3 with one flit each, grant immediately -> service order 0,1,2,3. Then refill VC0 and VC2 only -> order 0,2.
- Full/overflow: with B=2, write 5 flits to VC2 with no grants -> 4 stored, overflow_err=1 after the 5th write and stays high; other VCs unaffected.
- Zero mask: write dest=0 -> flit_rel pulses, no request ever asserted, next VC serviced.
- Reset mid-SERVE: assert rst while req=0000110 -> all outputs zero immediately, vc_not_empty=0. With IQ_STATS_EN, stats_cnt for that VC is unchanged from 0 after reset.
